// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand bypassing and ALU source selection.
// Also raises a load-use hazard flag against the instruction currently in decode.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SIDE_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
  input  logic                      ALUSrcAD,
  input  logic                      ALUSrcBD,
  input  logic                      RegWriteD,
  input  logic                      LoadD,
  input  logic [SIDE_WIDTH-1:0]     SideD,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      LoadE,
  output logic [SIDE_WIDTH-1:0]     SideE,
  output logic                      ValidE,
  output logic                      LoadUseHazard
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      src_a_pc;
    logic                      src_b_imm;
    logic                      reg_write;
    logic                      load;
    logic [SIDE_WIDTH-1:0]     side;
  } e_reg_t;

  e_reg_t e_d;
  e_reg_t e_q;

  always_comb begin
    e_d           = '0;
    e_d.valid     = ValidD;
    e_d.rd1       = RD1D;
    e_d.rd2       = RD2D;
    e_d.pc        = PCD;
    e_d.imm       = ImmExtD;
    e_d.rs1       = Rs1D;
    e_d.rs2       = Rs2D;
    e_d.rd        = RdD;
    e_d.alu_ctrl  = ALUControlD;
    e_d.src_a_pc  = ALUSrcAD;
    e_d.src_b_imm = ALUSrcBD;
    e_d.reg_write = RegWriteD;
    e_d.load      = LoadD;
    e_d.side      = SideD;
  end

  // ValidD/ValidE mark a real instruction; there is no ready. StallE holds the
  // slot, FlushE overrides a stall and inserts an all-zero bubble (add 0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else if (!StallE) begin
      e_q <= e_d;
    end
  end

  // x0 is hardwired zero, so a write to it in M/W must never be bypassed.
  logic fwd_a_mem;
  logic fwd_a_wb;
  logic fwd_b_mem;
  logic fwd_b_wb;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  always_comb begin
    fwd_a_mem = RegWriteM && (RdM == e_q.rs1) && (e_q.rs1 != '0);
    fwd_a_wb  = RegWriteW && (RdW == e_q.rs1) && (e_q.rs1 != '0);
    fwd_b_mem = RegWriteM && (RdM == e_q.rs2) && (e_q.rs2 != '0);
    fwd_b_wb  = RegWriteW && (RdW == e_q.rs2) && (e_q.rs2 != '0);

    if (fwd_a_mem)     fwd_a = ALUResultM;
    else if (fwd_a_wb) fwd_a = ResultW;
    else               fwd_a = e_q.rd1;

    if (fwd_b_mem)     fwd_b = ALUResultM;
    else if (fwd_b_wb) fwd_b = ResultW;
    else               fwd_b = e_q.rd2;
  end

  assign SrcA       = e_q.src_a_pc  ? e_q.pc  : fwd_a;
  assign SrcB       = e_q.src_b_imm ? e_q.imm : fwd_b;
  assign WriteDataE = fwd_b;
  assign ALUControl = e_q.alu_ctrl;
  assign RdE        = e_q.rd;
  assign RegWriteE  = e_q.reg_write;
  assign LoadE      = e_q.load;
  assign SideE      = e_q.side;
  assign ValidE     = e_q.valid;

  // Compared against live decode sources: the load result is not ready in time.
  assign LoadUseHazard = e_q.load && e_q.valid && (e_q.rd != '0) &&
                         ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for capture/forwarding,
// plus hand sequences for reset, stall, flush-over-stall and reset-during-stall.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [3:0]  ALUControlD;
  logic        ALUSrcAD, ALUSrcBD, RegWriteD, LoadD;
  logic [3:0]  SideD;
  logic [31:0] ALUResultM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [31:0] SrcA, SrcB, WriteDataE;
  logic [3:0]  ALUControl;
  logic [4:0]  RdE;
  logic        RegWriteE, LoadE, ValidE, LoadUseHazard;
  logic [3:0]  SideE;

  int n_cmp  = 0;
  int n_fail = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD),
    .LoadD(LoadD), .SideD(SideD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .WriteDataE(WriteDataE),
    .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE), .SideE(SideE),
    .ValidE(ValidE), .LoadUseHazard(LoadUseHazard)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, pc, imm;
    logic [3:0]  alu;
    logic        asel, bsel, regw, load;
    logic [3:0]  side;
    logic [31:0] alu_m;
    logic [4:0]  rd_m;
    logic        regw_m;
    logic [31:0] res_w;
    logic [4:0]  rd_w;
    logic        regw_w;
    logic [31:0] exp_srca, exp_srcb, exp_wd;
    logic        exp_haz;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
    RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; ALUControlD = '0;
    ALUSrcAD = 1'b0; ALUSrcBD = 1'b0; RegWriteD = 1'b0; LoadD = 1'b0; SideD = '0;
    ALUResultM = '0; RdM = '0; RegWriteM = 1'b0;
    ResultW = '0; RdW = '0; RegWriteW = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    ValidD = v.valid; Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    RD1D = v.rd1; RD2D = v.rd2; PCD = v.pc; ImmExtD = v.imm;
    ALUControlD = v.alu; ALUSrcAD = v.asel; ALUSrcBD = v.bsel;
    RegWriteD = v.regw; LoadD = v.load; SideD = v.side;
    ALUResultM = v.alu_m; RdM = v.rd_m; RegWriteM = v.regw_m;
    ResultW = v.res_w; RdW = v.rd_w; RegWriteW = v.regw_w;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".SrcA"},       SrcA, 32'h0);
    check({tag, ".SrcB"},       SrcB, 32'h0);
    check({tag, ".ALUControl"}, 32'(ALUControl), 32'h0);
    check({tag, ".ValidE"},     32'(ValidE), 32'h0);
    check({tag, ".RdE"},        32'(RdE), 32'h0);
    check({tag, ".LoadE"},      32'(LoadE), 32'h0);
    check({tag, ".RegWriteE"},  32'(RegWriteE), 32'h0);
    check({tag, ".SideE"},      32'(SideE), 32'h0);
    check({tag, ".LoadUse"},    32'(LoadUseHazard), 32'h0);
  endtask

  initial begin
    // hand-computed vectors; M/W buses are live during the check cycle
    tbl[0] = '{name:"capture", valid:1, rs1:5'd1, rs2:5'd2, rd:5'd6, rd1:32'd5, rd2:32'd9,
               pc:32'h100, imm:32'd7, alu:4'h0, asel:0, bsel:1, regw:1, load:0, side:4'h3,
               alu_m:0, rd_m:0, regw_m:0, res_w:0, rd_w:0, regw_w:0,
               exp_srca:32'd5, exp_srcb:32'd7, exp_wd:32'd9, exp_haz:0};
    tbl[1] = '{name:"mem_over_wb", valid:1, rs1:5'd3, rs2:5'd4, rd:5'd10, rd1:32'h11, rd2:32'h22,
               pc:32'h0, imm:32'h0, alu:4'h2, asel:0, bsel:0, regw:1, load:0, side:4'h0,
               alu_m:32'hAA, rd_m:5'd3, regw_m:1, res_w:32'hBB, rd_w:5'd3, regw_w:1,
               exp_srca:32'hAA, exp_srcb:32'h22, exp_wd:32'h22, exp_haz:0};
    tbl[2] = '{name:"wb_only", valid:1, rs1:5'd3, rs2:5'd4, rd:5'd10, rd1:32'h11, rd2:32'h22,
               pc:32'h0, imm:32'h0, alu:4'h2, asel:0, bsel:0, regw:1, load:0, side:4'h0,
               alu_m:32'hAA, rd_m:5'd3, regw_m:0, res_w:32'hBB, rd_w:5'd3, regw_w:1,
               exp_srca:32'hBB, exp_srcb:32'h22, exp_wd:32'h22, exp_haz:0};
    tbl[3] = '{name:"x0_no_fwd", valid:1, rs1:5'd5, rs2:5'd0, rd:5'd11, rd1:32'h33, rd2:32'h0,
               pc:32'h0, imm:32'h0, alu:4'h1, asel:0, bsel:0, regw:1, load:0, side:4'h5,
               alu_m:32'h55, rd_m:5'd0, regw_m:1, res_w:32'h66, rd_w:5'd0, regw_w:1,
               exp_srca:32'h33, exp_srcb:32'h0, exp_wd:32'h0, exp_haz:0};
    tbl[4] = '{name:"pc_src", valid:1, rs1:5'd1, rs2:5'd7, rd:5'd12, rd1:32'h1, rd2:32'h77,
               pc:32'h1000, imm:32'h2000, alu:4'h0, asel:1, bsel:1, regw:1, load:0, side:4'h8,
               alu_m:32'h99, rd_m:5'd7, regw_m:1, res_w:32'h0, rd_w:5'd0, regw_w:0,
               exp_srca:32'h1000, exp_srcb:32'h2000, exp_wd:32'h99, exp_haz:0};
    tbl[5] = '{name:"wb_fwd_b", valid:1, rs1:5'd1, rs2:5'd8, rd:5'd13, rd1:32'h10, rd2:32'h88,
               pc:32'h0, imm:32'h0, alu:4'h7, asel:0, bsel:0, regw:1, load:0, side:4'h0,
               alu_m:32'hDD, rd_m:5'd9, regw_m:1, res_w:32'hCC, rd_w:5'd8, regw_w:1,
               exp_srca:32'h10, exp_srcb:32'hCC, exp_wd:32'hCC, exp_haz:0};
    tbl[6] = '{name:"load_use", valid:1, rs1:5'd1, rs2:5'd4, rd:5'd4, rd1:32'h20, rd2:32'h0,
               pc:32'h0, imm:32'h4, alu:4'hB, asel:0, bsel:1, regw:1, load:1, side:4'h0,
               alu_m:0, rd_m:0, regw_m:0, res_w:0, rd_w:0, regw_w:0,
               exp_srca:32'h20, exp_srcb:32'h4, exp_wd:32'h0, exp_haz:1};
    tbl[7] = '{name:"load_rd0", valid:1, rs1:5'd0, rs2:5'd0, rd:5'd0, rd1:32'h0, rd2:32'h0,
               pc:32'h0, imm:32'h8, alu:4'h0, asel:0, bsel:1, regw:0, load:1, side:4'h0,
               alu_m:0, rd_m:0, regw_m:0, res_w:0, rd_w:0, regw_w:0,
               exp_srca:32'h0, exp_srcb:32'h8, exp_wd:32'h0, exp_haz:0};
    tbl[8] = '{name:"load_invalid", valid:0, rs1:5'd4, rs2:5'd4, rd:5'd4, rd1:32'h44, rd2:32'h45,
               pc:32'h0, imm:32'h0, alu:4'h0, asel:0, bsel:0, regw:1, load:1, side:4'h0,
               alu_m:0, rd_m:0, regw_m:0, res_w:0, rd_w:0, regw_w:0,
               exp_srca:32'h44, exp_srcb:32'h45, exp_wd:32'h45, exp_haz:0};
    tbl[9] = '{name:"no_regwrite", valid:1, rs1:5'd6, rs2:5'd6, rd:5'd1, rd1:32'h60, rd2:32'h61,
               pc:32'h0, imm:32'h0, alu:4'h3, asel:0, bsel:0, regw:1, load:0, side:4'hF,
               alu_m:32'hE1, rd_m:5'd6, regw_m:0, res_w:32'hE2, rd_w:5'd6, regw_w:0,
               exp_srca:32'h60, exp_srcb:32'h61, exp_wd:32'h61, exp_haz:0};

    // reset with arbitrary D inputs and forwarding-capable buses
    drive_idle();
    rst_n = 1'b0;
    ValidD = 1'b1; LoadD = 1'b1; RegWriteD = 1'b1; RdD = 5'd3; Rs1D = 5'd3; Rs2D = 5'd3;
    RD1D = 32'hDEAD; RD2D = 32'hBEEF; ImmExtD = 32'h1234; ALUControlD = 4'h5; SideD = 4'hA;
    ALUResultM = 32'hAA; RdM = 5'd3; RegWriteM = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset.WriteDataE", WriteDataE, 32'h0);
    rst_n = 1'b1;
    drive_idle();

    for (int i = 0; i < 10; i++) begin
      drive_vec(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      check({tbl[i].name, ".SrcA"},       SrcA, tbl[i].exp_srca);
      check({tbl[i].name, ".SrcB"},       SrcB, tbl[i].exp_srcb);
      check({tbl[i].name, ".WriteDataE"}, WriteDataE, tbl[i].exp_wd);
      check({tbl[i].name, ".LoadUse"},    32'(LoadUseHazard), 32'(tbl[i].exp_haz));
      check({tbl[i].name, ".ALUControl"}, 32'(ALUControl), 32'(tbl[i].alu));
      check({tbl[i].name, ".RdE"},        32'(RdE), 32'(tbl[i].rd));
      check({tbl[i].name, ".ValidE"},     32'(ValidE), 32'(tbl[i].valid));
      check({tbl[i].name, ".RegWriteE"},  32'(RegWriteE), 32'(tbl[i].regw));
      check({tbl[i].name, ".LoadE"},      32'(LoadE), 32'(tbl[i].load));
      check({tbl[i].name, ".SideE"},      32'(SideE), 32'(tbl[i].side));
    end

    // load in E, dependent instruction arrives in decode, stall, then flush+stall
    drive_idle();
    ValidD = 1'b1; LoadD = 1'b1; RegWriteD = 1'b1; RdD = 5'd4; Rs1D = 5'd1; Rs2D = 5'd2;
    RD1D = 32'h40; RD2D = 32'h50;
    @(posedge clk);
    @(negedge clk);
    ValidD = 1'b1; LoadD = 1'b0; RdD = 5'd9; Rs1D = 5'd5; Rs2D = 5'd4; RD1D = 32'h111;
    #1;
    check("lu.hazard_live", 32'(LoadUseHazard), 32'h1);
    StallE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall.RdE",    32'(RdE), 32'd4);
    check("stall.LoadE",  32'(LoadE), 32'h1);
    check("stall.SrcA",   SrcA, 32'h40);
    check("stall.hazard", 32'(LoadUseHazard), 32'h1);
    FlushE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("flush_stall");
    FlushE = 1'b0; StallE = 1'b0;

    // reset asserted while stalled still clears the register
    drive_idle();
    ValidD = 1'b1; Rs1D = 5'd1; RD1D = 32'h77; ALUControlD = 4'h6; RdD = 5'd2; RegWriteD = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst.SrcA", SrcA, 32'h77);
    StallE = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_stall");
    rst_n = 1'b1; StallE = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
